// File: rtl/writeback_buffer.sv
// Writeback buffer: a small circular queue of pending register-file writes.
// Results are drained one per cycle into the register file while the write
// port is free. Every occupied entry is visible to the read ports through
// forwarding, so a pending result is never hidden behind a stale register.
module writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_reg,
  input  logic [31:0]             in_data,
  input  logic                    stall,
  output logic                    RegWrite,
  output logic [4:0]              WriteReg,
  output logic [31:0]             WriteData,
  input  logic [4:0]              ReadReg1,
  input  logic [4:0]              ReadReg2,
  output logic                    fwd1_hit,
  output logic                    fwd2_hit,
  output logic [31:0]             fwd1_data,
  output logic [31:0]             fwd2_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] headQ, headD;
  logic [PW-1:0] tailQ, tailD;
  logic [CW-1:0] countQ, countD;

  logic [4:0]  regMem  [DEPTH];
  logic [31:0] dataMem [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic [PW-1:0] slot;

  // A full buffer refuses new results even when the head drains this cycle,
  // which keeps in_ready a pure function of the registered occupancy.
  assign in_ready  = (countQ < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  // Writes to register 0 are swallowed here so they never reach the file.
  assign push      = accept & (in_reg != 5'd0);
  assign RegWrite  = (countQ != '0) & ~stall;
  assign pop       = RegWrite;
  assign WriteReg  = regMem[headQ];
  assign WriteData = dataMem[headQ];
  assign count     = countQ;

  // Next pointers and occupancy: push advances the tail, pop the head, and
  // both together leave the occupancy unchanged.
  always_comb begin
    headD  = headQ;
    tailD  = tailQ;
    countD = countQ;
    if (push) tailD = tailQ + PW'(1);
    if (pop)  headD = headQ + PW'(1);
    case ({push, pop})
      2'b10:   countD = countQ + CW'(1);
      2'b01:   countD = countQ - CW'(1);
      default: countD = countQ;
    endcase
  end

  // Occupancy state; reset discards every pending entry immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
    end
  end

  // Entry storage is only meaningful while occupied, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      regMem[tailQ]  <= in_reg;
      dataMem[tailQ] <= in_data;
    end
  end

  // Forwarding walks entries oldest to newest so the newest match wins; the
  // head being written this cycle is still occupied and still forwards.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = headQ + PW'(k);
      if (CW'(k) < countQ) begin
        if ((ReadReg1 != 5'd0) && (regMem[slot] == ReadReg1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = dataMem[slot];
        end
        if ((ReadReg2 != 5'd0) && (regMem[slot] == ReadReg2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = dataMem[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: a vector table covering single writes,
// register-0 drops, fill/full/drain and forwarding, followed by hand-written
// sequences for back-to-back accept+pop with pointer wrap and mid-drain reset.
module tb_writeback_buffer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;

  int errCount;
  int checkCount;

  typedef struct {
    logic        vIn;
    logic [4:0]  inReg;
    logic [31:0] inData;
    logic        stallIn;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        expReady;
    logic        expRw;
    logic [4:0]  expWreg;
    logic [31:0] expWdata;
    logic [2:0]  expCount;
    logic        expH1;
    logic [31:0] expD1;
    logic        expH2;
    logic [31:0] expD2;
  } vec_t;

  vec_t vecs [21];
  logic [36:0] model [$];

  writeback_buffer #(.DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .stall     (stall),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mkVec(
    input logic vIn, input logic [4:0] inReg, input logic [31:0] inData,
    input logic stallIn, input logic [4:0] rr1, input logic [4:0] rr2,
    input logic expReady, input logic expRw, input logic [4:0] expWreg,
    input logic [31:0] expWdata, input logic [2:0] expCount,
    input logic expH1, input logic [31:0] expD1,
    input logic expH2, input logic [31:0] expD2);
    vec_t v;
    v.vIn = vIn; v.inReg = inReg; v.inData = inData; v.stallIn = stallIn;
    v.rr1 = rr1; v.rr2 = rr2; v.expReady = expReady; v.expRw = expRw;
    v.expWreg = expWreg; v.expWdata = expWdata; v.expCount = expCount;
    v.expH1 = expH1; v.expD1 = expD1; v.expH2 = expH2; v.expD2 = expD2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge; outputs are sampled 1ns later,
  // well before the next rising edge commits the cycle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    in_valid = v.vIn;
    in_reg   = v.inReg;
    in_data  = v.inData;
    stall    = v.stallIn;
    ReadReg1 = v.rr1;
    ReadReg2 = v.rr2;
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(v.expReady));
    checkOutput($sformatf("v%0d.RegWrite", i), 32'(RegWrite), 32'(v.expRw));
    if (v.expRw) begin
      checkOutput($sformatf("v%0d.WriteReg", i), 32'(WriteReg), 32'(v.expWreg));
      checkOutput($sformatf("v%0d.WriteData", i), WriteData, v.expWdata);
    end
    checkOutput($sformatf("v%0d.count", i), 32'(count), 32'(v.expCount));
    checkOutput($sformatf("v%0d.fwd1_hit", i), 32'(fwd1_hit), 32'(v.expH1));
    checkOutput($sformatf("v%0d.fwd1_data", i), fwd1_data, v.expD1);
    checkOutput($sformatf("v%0d.fwd2_hit", i), 32'(fwd2_hit), 32'(v.expH2));
    checkOutput($sformatf("v%0d.fwd2_data", i), fwd2_data, v.expD2);
  endtask

  task automatic driveCycle(input logic v, input logic [4:0] r,
                            input logic [31:0] d, input logic s);
    vec_t t;
    t = mkVec(v, r, d, s, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(t);
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;

    //          vIn reg    data          stl rr1    rr2    rdy rw wreg   wdata         cnt   h1 d1            h2 d2
    vecs[0]  = mkVec(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mkVec(0, 5'd0, 32'h0,        0, 5'd5, 5'd0, 1, 1, 5'd5, 32'hDEADBEEF, 3'd1, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[2]  = mkVec(0, 5'd0, 32'h0,        0, 5'd5, 5'd0, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[3]  = mkVec(1, 5'd0, 32'h1234,     0, 5'd0, 5'd0, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[4]  = mkVec(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[5]  = mkVec(1, 5'd1, 32'h11,       1, 5'd2, 5'd4, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[6]  = mkVec(1, 5'd2, 32'h22,       1, 5'd2, 5'd4, 1, 0, 5'd0, 32'h0,        3'd1, 0, 32'h0,        0, 32'h0);
    vecs[7]  = mkVec(1, 5'd3, 32'h33,       1, 5'd2, 5'd4, 1, 0, 5'd0, 32'h0,        3'd2, 1, 32'h22,       0, 32'h0);
    vecs[8]  = mkVec(1, 5'd4, 32'h44,       1, 5'd2, 5'd4, 1, 0, 5'd0, 32'h0,        3'd3, 1, 32'h22,       0, 32'h0);
    vecs[9]  = mkVec(1, 5'd9, 32'h99,       1, 5'd2, 5'd4, 0, 0, 5'd0, 32'h0,        3'd4, 1, 32'h22,       1, 32'h44);
    vecs[10] = mkVec(1, 5'd9, 32'h99,       0, 5'd2, 5'd4, 0, 1, 5'd1, 32'h11,       3'd4, 1, 32'h22,       1, 32'h44);
    vecs[11] = mkVec(0, 5'd0, 32'h0,        0, 5'd2, 5'd4, 1, 1, 5'd2, 32'h22,       3'd3, 1, 32'h22,       1, 32'h44);
    vecs[12] = mkVec(0, 5'd0, 32'h0,        0, 5'd2, 5'd4, 1, 1, 5'd3, 32'h33,       3'd2, 0, 32'h0,        1, 32'h44);
    vecs[13] = mkVec(0, 5'd0, 32'h0,        0, 5'd2, 5'd4, 1, 1, 5'd4, 32'h44,       3'd1, 0, 32'h0,        1, 32'h44);
    vecs[14] = mkVec(0, 5'd0, 32'h0,        0, 5'd2, 5'd4, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[15] = mkVec(1, 5'd7, 32'hA,        1, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);
    vecs[16] = mkVec(1, 5'd7, 32'hB,        1, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0,        3'd1, 1, 32'hA,        0, 32'h0);
    vecs[17] = mkVec(0, 5'd0, 32'h0,        1, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0,        3'd2, 1, 32'hB,        0, 32'h0);
    vecs[18] = mkVec(0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 1, 1, 5'd7, 32'hA,        3'd2, 1, 32'hB,        0, 32'h0);
    vecs[19] = mkVec(0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 1, 1, 5'd7, 32'hB,        3'd1, 1, 32'hB,        0, 32'h0);
    vecs[20] = mkVec(0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0);

    // Reset state, with a live-looking request on the inputs.
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    stall = 1'b0; ReadReg1 = '0; ReadReg2 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    in_valid = 1'b1; in_reg = 5'd3; in_data = 32'h77; ReadReg1 = 5'd3; ReadReg2 = 5'd3;
    #1;
    checkOutput("rst.count", 32'(count), 32'd0);
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("rst.fwd1_hit", 32'(fwd1_hit), 32'd0);
    checkOutput("rst.fwd2_hit", 32'(fwd2_hit), 32'd0);
    checkOutput("rst.fwd1_data", fwd1_data, 32'd0);
    checkOutput("rst.fwd2_data", fwd2_data, 32'd0);
    in_valid = 1'b0;
    reset    = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Back-to-back accept and pop at occupancy 2, wrapping the pointers.
    model.delete();
    driveCycle(1, 5'd10, 32'h1010, 1); model.push_back({5'd10, 32'h1010});
    driveCycle(1, 5'd11, 32'h1111, 1); model.push_back({5'd11, 32'h1111});
    for (int i = 0; i < 10; i++) begin
      driveCycle(1, 5'(12 + i), 32'h2000 + 32'(i), 0);
      checkOutput($sformatf("wrap%0d.count", i), 32'(count), 32'd2);
      checkOutput($sformatf("wrap%0d.RegWrite", i), 32'(RegWrite), 32'd1);
      checkOutput($sformatf("wrap%0d.WriteReg", i), 32'(WriteReg), 32'(model[0][36:32]));
      checkOutput($sformatf("wrap%0d.WriteData", i), WriteData, model[0][31:0]);
      void'(model.pop_front());
      model.push_back({5'(12 + i), 32'h2000 + 32'(i)});
    end
    for (int i = 0; i < 2; i++) begin
      driveCycle(0, 5'd0, 32'h0, 0);
      checkOutput($sformatf("tail%0d.RegWrite", i), 32'(RegWrite), 32'd1);
      checkOutput($sformatf("tail%0d.WriteReg", i), 32'(WriteReg), 32'(model[0][36:32]));
      checkOutput($sformatf("tail%0d.WriteData", i), WriteData, model[0][31:0]);
      void'(model.pop_front());
    end
    driveCycle(0, 5'd0, 32'h0, 0);
    checkOutput("wrap.empty", 32'(count), 32'd0);

    // Reset asserted between edges while three writes are pending.
    driveCycle(1, 5'd20, 32'h20, 1);
    driveCycle(1, 5'd21, 32'h21, 1);
    driveCycle(1, 5'd22, 32'h22, 1);
    driveCycle(0, 5'd0, 32'h0, 0);
    ReadReg1 = 5'd20;
    #1;
    checkOutput("mid.count", 32'(count), 32'd3);
    checkOutput("mid.RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("mid.fwd1_hit", 32'(fwd1_hit), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst.RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("midrst.count", 32'(count), 32'd0);
    checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst.fwd1_hit", 32'(fwd1_hit), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      checkOutput($sformatf("post%0d.RegWrite", i), 32'(RegWrite), 32'd0);
      checkOutput($sformatf("post%0d.count", i), 32'(count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending-write entries (power of two, 2..16).
REQ-002 The block SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the producer presents a result.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the buffer can accept a result this cycle.
REQ-006 The block SHALL have port in_reg, input, 5, meaning the destination register index.
REQ-007 The block SHALL have port in_data, input, 32, meaning the result value.
REQ-008 The block SHALL have port stall, input, 1, meaning the register-file write port is blocked this cycle.
REQ-009 The block SHALL have port RegWrite, output, 1, meaning the write enable to the register file.
REQ-010 The block SHALL have port WriteReg, output, 5, meaning the register-file write address.
REQ-011 The block SHALL have port WriteData, output, 32, meaning the register-file write data.
REQ-012 The block SHALL have ports ReadReg1 and ReadReg2, input, 5 each, meaning the register indices currently being read from the register file.
REQ-013 The block SHALL have ports fwd1_hit and fwd2_hit, output, 1 each, meaning a pending write matches the corresponding read index.
REQ-014 The block SHALL have ports fwd1_data and fwd2_data, output, 32 each, meaning the forwarded value for the corresponding read port.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1, meaning the number of occupied entries.

Function
REQ-016 The block SHALL implement a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-017 The block SHALL drive in_ready = (count < DEPTH); when full, in_ready SHALL be 0 even if a drain occurs in the same cycle.
REQ-018 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-019 An accept with in_reg=0 SHALL be consumed without enqueueing, so register 0 is never written.
REQ-020 The block SHALL drive RegWrite = (count != 0) and (stall = 0), combinationally.
REQ-021 The block SHALL drive WriteReg and WriteData from the head entry; their values are don't-care while RegWrite=0.
REQ-022 On a rising edge with RegWrite=1, the head entry SHALL be popped, coinciding with the register-file write.
REQ-023 Latency: a result accepted at edge N into an empty buffer SHALL appear with RegWrite=1 during cycle N+1, provided stall=0.
REQ-024 A simultaneous accept and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 While stall=1, the head entry SHALL be held; count SHALL only grow.
REQ-026 fwdK_hit SHALL be 1 when ReadRegK != 0 and any occupied entry has a matching register index.
REQ-027 fwdK_data SHALL be the data of the newest (closest to tail) matching entry.
REQ-028 The head entry currently being written SHALL still count as a forwarding match during its write cycle.
REQ-029 When fwdK_hit=0, fwdK_data SHALL be 0.
REQ-030 Forwarding SHALL be purely combinational and SHALL NOT include the in_* inputs of the same cycle.
REQ-031 Duplicate destination indices in the queue SHALL be permitted and written in order (last value wins in the register file).

Reset
REQ-032 While reset=1: count=0, head=tail=0, RegWrite=0, in_ready=1, fwd1_hit=fwd2_hit=0, fwd1_data=fwd2_data=0.
REQ-033 Reset asserted mid-operation SHALL discard all pending entries immediately; no further register-file write SHALL issue for them.
REQ-034 Entry data storage SHALL need no reset; only occupancy state SHALL be reset.

Verification
REQ-035 Single write: accept (in_reg=5, in_data=0xDEADBEEF), stall=0 -> next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; count returns to 0 after that edge.
REQ-036 Fill and block: stall=1 with 4 accepts (regs 1..4) -> count=4, in_ready=0; release stall -> writes issue in order 1,2,3,4 on consecutive cycles.
REQ-037 Register 0 drop: accept in_reg=0, in_data=0x1234 -> count stays 0; RegWrite never asserts.
REQ-038 Forwarding: stall=1, enqueue (7,0xA) then (7,0xB); ReadReg1=7, ReadReg2=0 -> fwd1_hit=1, fwd1_data=0xB, fwd2_hit=0.
REQ-039 Simultaneous accept and pop with count=2 -> count stays 2; pointers wrap correctly over 10 such cycles with no lost or reordered writes.
REQ-040 Reset mid-drain: count=3 with stall=0, assert reset between edges -> RegWrite=0 at once; after release, count=0 and no stale writes occur.
